// File: rtl/kb_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// kb_mode_sequencer_pkg
// Shared definitions for the keyboard mode sequencer:
//   - PS/2 set-2 scan codes for digit keys 1..9
//   - break (F0) and extended (E0) prefix codes
//   - default control-key codes (pause, quit, next, prev)
//   - controller state encoding
//   - digit_of(): maps a scan code to its digit value, 0 when not a digit
// -----------------------------------------------------------------------------
package kb_mode_sequencer_pkg;

    localparam logic [7:0] SC_DIGIT_1 = 8'h16;
    localparam logic [7:0] SC_DIGIT_2 = 8'h1E;
    localparam logic [7:0] SC_DIGIT_3 = 8'h26;
    localparam logic [7:0] SC_DIGIT_4 = 8'h25;
    localparam logic [7:0] SC_DIGIT_5 = 8'h2E;
    localparam logic [7:0] SC_DIGIT_6 = 8'h36;
    localparam logic [7:0] SC_DIGIT_7 = 8'h3D;
    localparam logic [7:0] SC_DIGIT_8 = 8'h3E;
    localparam logic [7:0] SC_DIGIT_9 = 8'h46;

    localparam logic [7:0] SC_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] SC_PREFIX_EXT   = 8'hE0;

    localparam logic [7:0] SC_KEY_PAUSE = 8'h4D;
    localparam logic [7:0] SC_KEY_QUIT  = 8'h15;
    localparam logic [7:0] SC_KEY_NEXT  = 8'h31;
    localparam logic [7:0] SC_KEY_PREV  = 8'h32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } kb_state_e;

    // Digit value of a scan code; 0 means the code is not a digit key 1..9.
    function automatic logic [3:0] digit_of(input logic [7:0] code);
        logic [3:0] d;
        case (code)
            SC_DIGIT_1: d = 4'd1;
            SC_DIGIT_2: d = 4'd2;
            SC_DIGIT_3: d = 4'd3;
            SC_DIGIT_4: d = 4'd4;
            SC_DIGIT_5: d = 4'd5;
            SC_DIGIT_6: d = 4'd6;
            SC_DIGIT_7: d = 4'd7;
            SC_DIGIT_8: d = 4'd8;
            SC_DIGIT_9: d = 4'd9;
            default:    d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/kb_event_filter.sv
// -----------------------------------------------------------------------------
// kb_event_filter
// Turns the level kb_up strobe into single-cycle key events and strips PS/2
// break/extended prefixes together with the code that follows them.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   kb_up      in   key-released level from the PS/2 decoder
//   kb_data    in   scan code, valid while kb_up is high
//   evt_valid  out  1-cycle pulse: a clean (non-prefixed) key event this cycle
//   evt_code   out  scan code belonging to evt_valid
// evt_valid/evt_code are combinational so the top's registered outputs update
// on the posedge that directly follows the kb_up rising edge.
// -----------------------------------------------------------------------------
module kb_event_filter
    import kb_mode_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_up,
    input  logic [7:0] kb_data,
    output logic       evt_valid,
    output logic [7:0] evt_code
);

    logic kb_up_d_r;
    logic discard_r;
    logic edge_s;
    logic is_prefix_s;

    // kb_up_d resets high so a strobe held across reset release is not an event.
    assign edge_s      = kb_up & ~kb_up_d_r;
    assign is_prefix_s = (kb_data == SC_PREFIX_BREAK) || (kb_data == SC_PREFIX_EXT);
    assign evt_valid   = edge_s & ~is_prefix_s & ~discard_r;
    assign evt_code    = kb_data;

    // Edge history and prefix discard flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_up_d_r <= 1'b1;
            discard_r <= 1'b0;
        end else begin
            kb_up_d_r <= kb_up;
            if (edge_s) begin
                // A prefix arms the discard; any real code consumes it.
                // E0 F0 xx keeps discard set across both prefixes, so xx is dropped.
                discard_r <= is_prefix_s;
            end else begin
                discard_r <= discard_r;
            end
        end
    end

endmodule

// File: rtl/kb_mode_sequencer.sv
// -----------------------------------------------------------------------------
// kb_mode_sequencer
// Keyboard-driven mode controller for the image pipeline. Digit keys select a
// processing mode, next/prev keys move a per-mode step index, a pause key
// freezes RAM writes and a quit key returns to idle.
// Ports:
//   clk          in   system clock (posedge)
//   rst          in   asynchronous active-low reset
//   kb_up        in   key-released level strobe from PS/2 decoder
//   kb_data      in   scan code, valid while kb_up high
//   mode         out  active mode, 0 = idle
//   step         out  step index within the active mode
//   pic_select   out  PIC_MASK[mode-1] when mode != 0, else 0
//   pause        out  1 = RAM writes frozen
//   mode_change  out  1-cycle pulse whenever mode takes a new value
// All outputs are registered; a key event is reflected one cycle later.
// -----------------------------------------------------------------------------
module kb_mode_sequencer
    import kb_mode_sequencer_pkg::*;
#(
    parameter int          NUM_MODES = 5,
    parameter int          MODE_W    = 4,
    parameter logic [8:0]  PIC_MASK  = 9'b000000111,
    parameter int          NUM_STEPS = 8,
    parameter int          STEP_W    = 3,
    parameter logic [7:0]  KEY_PAUSE = SC_KEY_PAUSE,
    parameter logic [7:0]  KEY_QUIT  = SC_KEY_QUIT,
    parameter logic [7:0]  KEY_NEXT  = SC_KEY_NEXT,
    parameter logic [7:0]  KEY_PREV  = SC_KEY_PREV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kb_up,
    input  logic [7:0]        kb_data,
    output logic [MODE_W-1:0] mode,
    output logic [STEP_W-1:0] step,
    output logic              pic_select,
    output logic              pause,
    output logic              mode_change
);

    kb_state_e         state_r, state_nxt_s;
    logic [MODE_W-1:0] mode_r, mode_nxt_s;
    logic [STEP_W-1:0] step_r, step_nxt_s;
    logic              pause_r, pause_nxt_s;
    logic              pic_r, pic_nxt_s;
    logic              mode_change_r, mode_change_nxt_s;

    logic              evt_valid_s;
    logic [7:0]        evt_code_s;
    logic [3:0]        digit_s;
    logic              digit_ok_s;
    logic [MODE_W-1:0] key_mode_s;
    logic [STEP_W-1:0] step_inc_s;
    logic [STEP_W-1:0] step_dec_s;

    kb_event_filter u_filter (
        .clk       (clk),
        .rst_n     (rst),
        .kb_up     (kb_up),
        .kb_data   (kb_data),
        .evt_valid (evt_valid_s),
        .evt_code  (evt_code_s)
    );

    // Decode the event code into a selectable mode and the wrapped step neighbours.
    always_comb begin
        digit_s    = digit_of(evt_code_s);
        digit_ok_s = (digit_s != 4'd0) && (int'(digit_s) <= NUM_MODES);
        key_mode_s = MODE_W'(digit_s);
        step_inc_s = (step_r == STEP_W'(NUM_STEPS - 1)) ? STEP_W'(0) : step_r + STEP_W'(1);
        step_dec_s = (step_r == STEP_W'(0)) ? STEP_W'(NUM_STEPS - 1) : step_r - STEP_W'(1);
    end

    // Next-state and next-output logic; every path starts from "hold".
    always_comb begin
        state_nxt_s       = state_r;
        mode_nxt_s        = mode_r;
        step_nxt_s        = step_r;
        pause_nxt_s       = pause_r;
        mode_change_nxt_s = 1'b0;

        if (evt_valid_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (digit_ok_s) begin
                        state_nxt_s       = ST_RUN;
                        mode_nxt_s        = key_mode_s;
                        step_nxt_s        = STEP_W'(0);
                        mode_change_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (digit_ok_s && (key_mode_s != mode_r)) begin
                        mode_nxt_s        = key_mode_s;
                        step_nxt_s        = STEP_W'(0);
                        mode_change_nxt_s = 1'b1;
                    end else if (evt_code_s == KEY_NEXT) begin
                        step_nxt_s = step_inc_s;
                    end else if (evt_code_s == KEY_PREV) begin
                        step_nxt_s = step_dec_s;
                    end else if (evt_code_s == KEY_PAUSE) begin
                        state_nxt_s = ST_PAUSED;
                        pause_nxt_s = 1'b1;
                    end else if (evt_code_s == KEY_QUIT) begin
                        state_nxt_s       = ST_IDLE;
                        mode_nxt_s        = MODE_W'(0);
                        step_nxt_s        = STEP_W'(0);
                        pause_nxt_s       = 1'b0;
                        mode_change_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    if (evt_code_s == KEY_PAUSE) begin
                        state_nxt_s = ST_RUN;
                        pause_nxt_s = 1'b0;
                    end else if (evt_code_s == KEY_QUIT) begin
                        state_nxt_s       = ST_IDLE;
                        mode_nxt_s        = MODE_W'(0);
                        step_nxt_s        = STEP_W'(0);
                        pause_nxt_s       = 1'b0;
                        mode_change_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_PAUSED;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle.
                    state_nxt_s       = ST_IDLE;
                    mode_nxt_s        = MODE_W'(0);
                    step_nxt_s        = STEP_W'(0);
                    pause_nxt_s       = 1'b0;
                    mode_change_nxt_s = (mode_r != MODE_W'(0));
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Picture-select decode from the next mode so it lands with mode itself.
    always_comb begin
        pic_nxt_s = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            pic_nxt_s = (mode_nxt_s == MODE_W'(k)) ? PIC_MASK[k-1] : pic_nxt_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            mode_r        <= MODE_W'(0);
            step_r        <= STEP_W'(0);
            pause_r       <= 1'b0;
            pic_r         <= 1'b0;
            mode_change_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mode_r        <= mode_nxt_s;
            step_r        <= step_nxt_s;
            pause_r       <= pause_nxt_s;
            pic_r         <= pic_nxt_s;
            mode_change_r <= mode_change_nxt_s;
        end
    end

    assign mode        = mode_r;
    assign step        = step_r;
    assign pause       = pause_r;
    assign pic_select  = pic_r;
    assign mode_change = mode_change_r;

endmodule
